// File: rtl/beep_pkg.sv
// Shared definitions for the buzzer engine: mode codes, note half-period table and melody ROM.
// Pure constants and elaboration-time helpers; no logic of its own.
package beep_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_TONE   = 2'b01,
        MODE_SCALE  = 2'b10,
        MODE_MELODY = 2'b11
    } mode_e;

    localparam int HP_W      = 17;
    localparam int NUM_NOTES = 7;

    // Half-period counts at 50 MHz, index 1..7 = DO..XI; index 0 is a rest.
    function automatic logic [HP_W-1:0] hp_50m(input logic [3:0] note);
        case (note)
            4'd1:    return 17'd95420;
            4'd2:    return 17'd85034;
            4'd3:    return 17'd75758;
            4'd4:    return 17'd71633;
            4'd5:    return 17'd63776;
            4'd6:    return 17'd56818;
            4'd7:    return 17'd50607;
            default: return 17'd0;
        endcase
    endfunction

    // Scaled in 64 bits so clocks that are not a multiple of 50 MHz keep their precision.
    function automatic logic [HP_W-1:0] hp_scaled(input logic [3:0] note, input int clk_freq,
                                                  input int tone_div);
        logic [63:0] v;
        v = 64'(hp_50m(note)) * 64'(clk_freq) / 64'd50_000_000 / 64'(tone_div);
        if (v < 64'd2)
            v = 64'd2;
        if (v > 64'h1FFFF)
            v = 64'h1FFFF;
        return v[HP_W-1:0];
    endfunction

    // Melody ROM; entries above 7 have no pitch and play as rests.
    function automatic logic [3:0] melody_at(input logic [5:0] idx);
        case (idx)
            6'd0:    return 4'd1;
            6'd1:    return 4'd0;
            6'd2:    return 4'd5;
            6'd3:    return 4'd8;
            6'd4:    return 4'd1;
            6'd5:    return 4'd2;
            6'd6:    return 4'd3;
            6'd7:    return 4'd4;
            6'd8:    return 4'd5;
            6'd9:    return 4'd0;
            6'd10:   return 4'd5;
            6'd11:   return 4'd6;
            6'd12:   return 4'd7;
            6'd13:   return 4'd6;
            6'd14:   return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/beep_note_rom.sv
// Note index to tone half-period in sys_clk cycles, scaled for CLK_FREQ and TONE_DIV.
// Combinational, zero latency; the table folds to constants at elaboration.
module beep_note_rom
    import beep_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TONE_DIV = 1
) (
    input  logic [3:0]      note,
    output logic [HP_W-1:0] half_period
);

    localparam logic [HP_W-1:0] HP_TAB [8] = '{
        hp_scaled(4'd0, CLK_FREQ, TONE_DIV),
        hp_scaled(4'd1, CLK_FREQ, TONE_DIV),
        hp_scaled(4'd2, CLK_FREQ, TONE_DIV),
        hp_scaled(4'd3, CLK_FREQ, TONE_DIV),
        hp_scaled(4'd4, CLK_FREQ, TONE_DIV),
        hp_scaled(4'd5, CLK_FREQ, TONE_DIV),
        hp_scaled(4'd6, CLK_FREQ, TONE_DIV),
        hp_scaled(4'd7, CLK_FREQ, TONE_DIV)
    };

    always_comb begin
        half_period = HP_TAB[0];
        if (note <= 4'd7)
            half_period = HP_TAB[note[2:0]];
    end

endmodule

// File: rtl/beep_player.sv
// Buzzer tone/melody engine: off, held tone, looping scale, one-shot melody with rests.
// All outputs registered, one cycle after inputs; free-running, no backpressure.
module beep_player
    import beep_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int STEP_MS  = 500,
    parameter int SEQ_LEN  = 16,
    parameter int TONE_DIV = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] mode,
    input  logic [2:0] note_sel,
    output logic       beep,
    output logic [3:0] note_idx,
    output logic       busy,
    output logic       done
);

    localparam int STEP_CYC = CLK_FREQ / 1000 * STEP_MS;
    localparam int STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    // Wide enough for both the melody and the 7-note scale.
    localparam int SEQ_W    = ($clog2(SEQ_LEN) > 3) ? $clog2(SEQ_LEN) : 3;

    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_CYC - 1);
    localparam logic [SEQ_W-1:0]  SEQ_LAST   = SEQ_W'(SEQ_LEN - 1);
    localparam logic [SEQ_W-1:0]  SCALE_LAST = SEQ_W'(NUM_NOTES - 1);

    mode_e             mode_in, mode_q, mode_q_nxt;
    logic [2:0]        note_sel_q, note_sel_q_nxt;
    logic [STEP_W-1:0] step_cnt, step_nxt;
    logic [SEQ_W-1:0]  seq_idx, seq_nxt;
    logic [HP_W-1:0]   tone_cnt, tone_nxt, half_period;
    logic              fin, fin_nxt;
    logic              beep_nxt, done_nxt, busy_nxt;
    logic [3:0]        note_nxt, cur_note;
    logic              stepping;

    function automatic logic [3:0] note_of(input mode_e m, input logic [SEQ_W-1:0] idx,
                                           input logic [2:0] sel, input logic f);
        logic [3:0] n;
        case (m)
            MODE_TONE:   n = (sel == 3'd7) ? 4'd0 : {1'b0, sel} + 4'd1;
            MODE_SCALE:  n = 4'(idx) + 4'd1;
            MODE_MELODY: n = f ? 4'd0 : melody_at(6'(idx));
            default:     n = 4'd0;
        endcase
        return (n > 4'd7) ? 4'd0 : n;
    endfunction

    assign mode_in  = mode_e'(mode);
    assign cur_note = note_of(mode_q, seq_idx, note_sel_q, fin);
    assign stepping = (mode_q == MODE_SCALE) || (mode_q == MODE_MELODY && !fin);

    beep_note_rom #(
        .CLK_FREQ (CLK_FREQ),
        .TONE_DIV (TONE_DIV)
    ) u_note_rom (
        .note        (cur_note),
        .half_period (half_period)
    );

    // Branch order encodes priority: mode change > note change > step end > tone toggle.
    always_comb begin
        mode_q_nxt     = mode_in;
        note_sel_q_nxt = note_sel;
        step_nxt       = step_cnt;
        seq_nxt        = seq_idx;
        tone_nxt       = tone_cnt;
        fin_nxt        = fin;
        beep_nxt       = beep;
        done_nxt       = 1'b0;

        if (mode_in != mode_q) begin
            step_nxt = '0;
            seq_nxt  = '0;
            tone_nxt = '0;
            fin_nxt  = 1'b0;
            beep_nxt = 1'b1;
        end else if (mode_q == MODE_TONE && note_sel != note_sel_q) begin
            tone_nxt = '0;
            beep_nxt = 1'b1;
        end else if (stepping && step_cnt == STEP_LAST) begin
            step_nxt = '0;
            tone_nxt = '0;
            beep_nxt = 1'b1;
            if (mode_q == MODE_SCALE) begin
                seq_nxt = (seq_idx == SCALE_LAST) ? '0 : seq_idx + SEQ_W'(1);
            end else if (seq_idx == SEQ_LAST) begin
                fin_nxt  = 1'b1;
                done_nxt = 1'b1;
            end else begin
                seq_nxt = seq_idx + SEQ_W'(1);
            end
        end else begin
            if (stepping)
                step_nxt = step_cnt + STEP_W'(1);
            if (cur_note == 4'd0) begin
                tone_nxt = '0;
                beep_nxt = 1'b1;
            end else if (tone_cnt == half_period - HP_W'(1)) begin
                tone_nxt = '0;
                beep_nxt = ~beep;
            end else begin
                tone_nxt = tone_cnt + HP_W'(1);
            end
        end

        note_nxt = note_of(mode_q_nxt, seq_nxt, note_sel_q_nxt, fin_nxt);
        case (mode_q_nxt)
            MODE_TONE:   busy_nxt = (note_sel_q_nxt != 3'd7);
            MODE_SCALE:  busy_nxt = 1'b1;
            MODE_MELODY: busy_nxt = ~fin_nxt;
            default:     busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            mode_q     <= MODE_OFF;
            note_sel_q <= '0;
            step_cnt   <= '0;
            seq_idx    <= '0;
            tone_cnt   <= '0;
            fin        <= 1'b0;
            beep       <= 1'b1;
            note_idx   <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mode_q     <= mode_q_nxt;
            note_sel_q <= note_sel_q_nxt;
            step_cnt   <= step_nxt;
            seq_idx    <= seq_nxt;
            tone_cnt   <= tone_nxt;
            fin        <= fin_nxt;
            beep       <= beep_nxt;
            note_idx   <= note_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule
